// File: rtl/trap_arbiter_if.sv
// trap_arbiter_if: pipeline exception/interrupt inputs and CSR trap outputs of the trap arbiter
interface trap_arbiter_if;
  logic        stall_mmu;
  logic        if_exc_v;
  logic [3:0]  if_exc_cause;
  logic [31:0] if_pc;
  logic [31:0] if_va;
  logic        id_exc_v;
  logic [3:0]  id_exc_cause;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        mem_exc_v;
  logic [3:0]  mem_exc_cause;
  logic [31:0] mem_pc;
  logic [31:0] mem_va;
  logic        mem_valid;
  logic        msip;
  logic        mtip;
  logic        meip;
  logic [31:0] mie;
  logic        mstatus_mie;
  logic [1:0]  priv;
  logic        xret_redirect;
  logic        csr_branch_signal;
  logic        trap_valid;
  logic [4:0]  trap_id;
  logic [31:0] trap_pc;
  logic [31:0] trap_inst;
  logic [31:0] trap_va_imem;
  logic [31:0] trap_va_dmem;
  logic        flush_req;
  logic        busy;
  logic        err_timeout;
  modport master (
    input  stall_mmu, if_exc_v, if_exc_cause, if_pc, if_va, id_exc_v, id_exc_cause, id_pc, id_inst,
           mem_exc_v, mem_exc_cause, mem_pc, mem_va, mem_valid, msip, mtip, meip, mie, mstatus_mie,
           priv, xret_redirect, csr_branch_signal,
    output trap_valid, trap_id, trap_pc, trap_inst, trap_va_imem, trap_va_dmem, flush_req, busy,
           err_timeout
  );
  modport slave (
    output stall_mmu, if_exc_v, if_exc_cause, if_pc, if_va, id_exc_v, id_exc_cause, id_pc, id_inst,
           mem_exc_v, mem_exc_cause, mem_pc, mem_va, mem_valid, msip, mtip, meip, mie, mstatus_mie,
           priv, xret_redirect, csr_branch_signal,
    input  trap_valid, trap_id, trap_pc, trap_inst, trap_va_imem, trap_va_dmem, flush_req, busy,
           err_timeout
  );
endinterface

// File: rtl/trap_arbiter.sv
// trap_arbiter: picks one trap per cycle and sequences flush, single-cycle commit and redirect wait
module trap_arbiter #(
  parameter int INT_HOLDOFF  = 2,
  parameter int HOLD_TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  trap_arbiter_if.master bus
);
  localparam int HW = INT_HOLDOFF > 0 ? $clog2(INT_HOLDOFF + 1) : 1;
  localparam int TW = HOLD_TIMEOUT > 1 ? $clog2(HOLD_TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, HOLD, COMMIT, WAIT} state_t;
  state_t state, state_nxt;
  logic [HW-1:0] holdoff;
  logic [TW-1:0] tcnt;
  logic mei, msi, mti, int_en, int_take, win;
  logic [4:0] w_id;
  logic [31:0] w_pc, w_inst, w_va_imem, w_va_dmem;
  logic unused_mie;
  assign unused_mie = ^{bus.mie[31:12], bus.mie[10:8], bus.mie[6:4], bus.mie[2:0]};
  // an xret in the same cycle masks interrupts so the returning code makes progress
  always_comb begin
    mei = bus.meip & bus.mie[11];
    msi = bus.msip & bus.mie[3];
    mti = bus.mtip & bus.mie[7];
    int_en = (bus.priv != 2'd3 || bus.mstatus_mie) && holdoff == '0 && !bus.xret_redirect;
    int_take = int_en && bus.mem_valid && (mei || msi || mti);
    win = bus.mem_exc_v || int_take || bus.id_exc_v || bus.if_exc_v;
    w_id = bus.mem_exc_v ? {1'b0, bus.mem_exc_cause} :
           int_take      ? {1'b1, mei ? 4'd11 : msi ? 4'd3 : 4'd7} :
           bus.id_exc_v  ? {1'b0, bus.id_exc_cause} : {1'b0, bus.if_exc_cause};
    w_pc = (bus.mem_exc_v || int_take) ? bus.mem_pc : bus.id_exc_v ? bus.id_pc : bus.if_pc;
    w_inst = (!bus.mem_exc_v && !int_take && bus.id_exc_v) ? bus.id_inst : '0;
    w_va_imem = (!bus.mem_exc_v && !int_take && !bus.id_exc_v) ? bus.if_va : '0;
    w_va_dmem = bus.mem_exc_v ? bus.mem_va : '0;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = !win ? IDLE : bus.stall_mmu ? HOLD : COMMIT;
      HOLD:    state_nxt = bus.stall_mmu ? HOLD : COMMIT;
      COMMIT:  state_nxt = WAIT;
      default: state_nxt = bus.csr_branch_signal ? IDLE : WAIT;
    endcase
  end
  assign bus.trap_valid = state == COMMIT;
  assign bus.flush_req = state != IDLE;
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      holdoff <= '0;
      tcnt <= '0;
      bus.err_timeout <= 1'b0;
      bus.trap_id <= '0;
      bus.trap_pc <= '0;
      bus.trap_inst <= '0;
      bus.trap_va_imem <= '0;
      bus.trap_va_dmem <= '0;
    end else begin
      state <= state_nxt;
      holdoff <= bus.xret_redirect ? HW'(INT_HOLDOFF) : holdoff != '0 ? holdoff - 1'b1 : holdoff;
      tcnt <= state != HOLD ? '0 : tcnt == TW'(HOLD_TIMEOUT) ? tcnt : tcnt + 1'b1;
      if (state == HOLD && tcnt == TW'(HOLD_TIMEOUT - 1)) bus.err_timeout <= 1'b1;
      if (state == IDLE && win) begin
        bus.trap_id <= w_id;
        bus.trap_pc <= w_pc;
        bus.trap_inst <= w_inst;
        bus.trap_va_imem <= w_va_imem;
        bus.trap_va_dmem <= w_va_dmem;
      end
    end
  end
endmodule

// File: doc/trap_arbiter.md
Name: trap_arbiter

Overview:
- Selects one trap per cycle from the pending synchronous exceptions (IF, ID and MEM stages) and the machine interrupts (msip, mtip, meip).
- Sequences trap entry: holds through MMU stalls, flushes the pipeline, pulses a single registered trap request into the CSR file, then waits for the redirect.
- Sits between the pipeline stage exception outputs and the csr_handler trap inputs (csr_trapID, csr_trapPC, faulting_*).

Parameters:
- INT_HOLDOFF, 2, cycles after an mret/sret redirect during which interrupts are masked (guarantees forward progress).
- HOLD_TIMEOUT, 255, max cycles spent in HOLD before watchdog flag err_timeout sets (sticky until rst).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- stall_mmu  in  1  MMU stall; no trap may commit while high
- if_exc_v  in  1  IF-stage exception valid
- if_exc_cause  in  4  IF cause (1, 12)
- if_pc  in  32  IF PC
- if_va  in  32  faulting IMEM virtual address
- id_exc_v  in  1  ID-stage exception valid (illegal, ecall, ebreak)
- id_exc_cause  in  4  ID cause (2, 3, 8, 9, 11)
- id_pc  in  32  ID PC
- id_inst  in  32  ID instruction word
- mem_exc_v  in  1  MEM-stage exception valid
- mem_exc_cause  in  4  MEM cause (4, 5, 6, 7, 13, 15)
- mem_pc  in  32  MEM PC
- mem_va  in  32  faulting DMEM virtual address
- mem_valid  in  1  MEM holds a live (non-bubble) instruction
- msip  in  1  software interrupt pending
- mtip  in  1  timer interrupt pending
- meip  in  1  external interrupt pending
- mie  in  32  CSR mie
- mstatus_mie  in  1  mstatus.MIE
- priv  in  2  current privilege (3 = M)
- xret_redirect  in  1  1-cycle pulse: mret/sret redirect taken
- csr_branch_signal  in  1  CSR file trap redirect acknowledge
- trap_valid  out  1  1-cycle trap commit strobe
- trap_id  out  5  [4] interrupt flag, [3:0] cause
- trap_pc  out  32  PC to save in mepc
- trap_inst  out  32  faulting instruction (0 if not ID)
- trap_va_imem  out  32  IMEM fault address
- trap_va_dmem  out  32  DMEM fault address
- flush_req  out  1  pipeline flush (FLUSH_ALL request)
- busy  out  1  state != IDLE
- err_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset: state IDLE. All outputs 0. Holdoff counter 0, timeout counter 0.
- Interrupt enable: int_en = (priv != 3 || mstatus_mie) && holdoff == 0. Pending: MEI = meip & mie[11], MSI = msip & mie[3], MTI = mtip & mie[7]. Interrupt priority: MEI > MSI > MTI.
- Global priority (oldest first): mem_exc_v > interrupt (int_en and mem_valid, taken at mem_pc) > id_exc_v > if_exc_v. The winner and its PC/VA/inst are captured in registers in IDLE.
- trap_id: exception = {1'b0, cause}; interrupt = {1'b1, 11/3/7}. Unused fault fields are driven 0.
- States:
  - IDLE: on any winner, capture it and assert flush_req the next cycle. Go to COMMIT if stall_mmu=0, else HOLD.
  - HOLD: flush_req held high, capture frozen, timeout counter increments. On stall_mmu=0 go to COMMIT. When the counter reaches HOLD_TIMEOUT, set err_timeout; the FSM stays in HOLD.
  - COMMIT: trap_valid=1 for exactly one cycle with the captured fields; flush_req=1. Go to WAIT.
  - WAIT: flush_req=1. On csr_branch_signal go to IDLE (0 latency). New requests are ignored.
- Latency: winner at cycle N, with no stall, gives trap_valid at N+1. Each stalled cycle adds one cycle.
- xret_redirect loads holdoff = INT_HOLDOFF, which then decrements each cycle to 0. Exceptions are not masked by holdoff.
- A simultaneous xret_redirect and interrupt: the interrupt is masked that cycle.
- An interrupt that deasserts after capture is still committed. No un-commit.
- rst in any state returns to IDLE the next edge. No trap_valid is emitted.

Test Plan:
- MEM load fault: mem_exc_v=1, cause 5, mem_pc=0x100, mem_va=0xDEAD0000 -> trap_valid at the next cycle, trap_id=0x05, trap_pc=0x100, trap_va_dmem=0xDEAD0000, flush_req high until csr_branch_signal.
- Simultaneous mem_exc (cause 7), id_exc (ecall cause 11), meip with int_en -> trap_id=0x07. A second pass with MEM clear -> trap_id=0x1B (interrupt 11).
- All interrupts pending with mie=0x888, priv=3, mstatus_mie=1 -> trap_id=0x1B. With meip=0 -> 0x13. With msip=0 -> 0x17. With mstatus_mie=0 and priv=3 -> no trap.
- stall_mmu high for 5 cycles after an IF fault (cause 12, if_va=0x4000) -> trap_valid exactly once, 6 cycles after the request, with fields unchanged.
- xret_redirect pulse while mtip pending (INT_HOLDOFF=2) -> no trap for 2 cycles, then trap_id=0x17.
- Stall held for HOLD_TIMEOUT+1 cycles -> err_timeout=1. rst -> err_timeout=0, state IDLE, no trap_valid emitted.
